// File: rtl/display_pkg.sv
// Shared constants and encodings for the display pattern generator:
// 640x480 default timing, pattern modes and bouncing-box direction.
package display_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    MODE_STATIC   = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_BOUNCE   = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  // Clamp a colour constant to the largest value a channel can hold.
  function automatic int sat_col(input int v, input int colw);
    int max_v;
    max_v = (1 << colw) - 1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/display_timing.sv
// Pixel/line counters with raw (unregistered, active-high) sync and
// data-enable decode straight from the counter values.
module display_timing #(
  parameter int H_ACTIVE = display_pkg::H_ACTIVE_DEF,
  parameter int H_FP     = display_pkg::H_FP_DEF,
  parameter int H_SYNC   = display_pkg::H_SYNC_DEF,
  parameter int H_BP     = display_pkg::H_BP_DEF,
  parameter int V_ACTIVE = display_pkg::V_ACTIVE_DEF,
  parameter int V_FP     = display_pkg::V_FP_DEF,
  parameter int V_SYNC   = display_pkg::V_SYNC_DEF,
  parameter int V_BP     = display_pkg::V_BP_DEF,
  parameter int CORDW    = 10
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_de,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] ONE    = CORDW'(1);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;

  always_comb begin
    sx_d = sx_q + ONE;
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + ONE;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  assign o_sx          = sx_q;
  assign o_sy          = sy_q;
  assign o_de          = (sx_q < H_ACT) && (sy_q < V_ACT);
  assign o_hs          = (sx_q >= HS_BEG) && (sx_q < HS_END);
  assign o_vs          = (sy_q >= VS_BEG) && (sy_q < VS_END);
  assign o_frame_start = (sx_q == '0) && (sy_q == '0);

endmodule

// File: rtl/display_pattern_gen.sv
// Test-pattern generator: timing core plus four selectable patterns, a
// per-axis bouncing-box FSM, a frame counter and one stage of output registers.
module display_pattern_gen
  import display_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CORDW     = 10,
  parameter int COLW      = 4,
  parameter int BOX       = 64,
  parameter int SPEED     = 2
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [1:0]       i_mode,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic             o_frame,
  output logic [COLW-1:0]  o_r,
  output logic [COLW-1:0]  o_g,
  output logic [COLW-1:0]  o_b
);

  localparam logic             HS_ON   = (HSYNC_POL != 0);
  localparam logic             VS_ON   = (VSYNC_POL != 0);
  localparam logic [CORDW-1:0] X_LO    = CORDW'(H_ACTIVE / 3);
  localparam logic [CORDW-1:0] X_HI    = CORDW'((2 * H_ACTIVE) / 3);
  localparam logic [CORDW-1:0] Y_LO    = CORDW'(V_ACTIVE / 3);
  localparam logic [CORDW-1:0] Y_HI    = CORDW'((2 * V_ACTIVE) / 3);
  localparam logic [CORDW-1:0] BAR_W   = CORDW'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);
  localparam logic [CORDW:0]   BOX_W   = (CORDW+1)'(BOX);
  localparam logic [CORDW:0]   SPEED_W = (CORDW+1)'(SPEED);
  localparam logic [CORDW-1:0] SPEED_C = CORDW'(SPEED);
  localparam logic [COLW-1:0]  ONES    = '1;
  localparam logic [COLW-1:0]  BG_R    = COLW'(sat_col(1, COLW));
  localparam logic [COLW-1:0]  BG_G    = COLW'(sat_col(3, COLW));
  localparam logic [COLW-1:0]  BG_B    = COLW'(sat_col(7, COLW));
  localparam int               GW      = CORDW + COLW + 5;

  logic [CORDW-1:0] sx, sy;
  logic             de_raw, hs_raw, vs_raw, frame_start;

  display_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CORDW    (CORDW)
  ) u_timing (
    .clk_pix       (clk_pix),
    .rst_pix       (rst_pix),
    .o_sx          (sx),
    .o_sy          (sy),
    .o_de          (de_raw),
    .o_hs          (hs_raw),
    .o_vs          (vs_raw),
    .o_frame_start (frame_start)
  );

  // Frame-level state: the _d values are what the frame starting now uses,
  // so the first pixel of a frame already sees the new mode and box position.
  mode_e            mode_q, mode_d;
  logic [7:0]       fc_q, fc_d;
  logic [CORDW-1:0] bx_d, by_d;

  assign mode_d = frame_start ? mode_e'(i_mode) : mode_q;
  assign fc_d   = frame_start ? fc_q + 8'd1 : fc_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int             LIMIT   = (gi == 0) ? H_ACTIVE : V_ACTIVE;
      localparam logic [CORDW:0] MAX_POS = (CORDW+1)'(LIMIT - BOX);

      logic [CORDW-1:0] pos_q, pos_d;
      dir_e             dir_q, dir_d;
      logic [CORDW:0]   pos_w, inc_w;

      assign pos_w = {1'b0, pos_q};
      assign inc_w = pos_w + SPEED_W;

      always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (frame_start) begin
          if (dir_q == DIR_INC) begin
            if (inc_w >= MAX_POS) begin
              pos_d = MAX_POS[CORDW-1:0];
              dir_d = DIR_DEC;
            end else begin
              pos_d = inc_w[CORDW-1:0];
            end
          end else if (pos_w <= SPEED_W) begin
            pos_d = '0;
            dir_d = DIR_INC;
          end else begin
            pos_d = pos_q - SPEED_C;
          end
        end
      end

      always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
          pos_q <= '0;
          dir_q <= DIR_INC;
        end else begin
          pos_q <= pos_d;
          dir_q <= dir_d;
        end
      end
    end
  endgenerate

  assign bx_d = g_axis[0].pos_d;
  assign by_d = g_axis[1].pos_d;

  // Last bar absorbs any remainder when H_ACTIVE is not a multiple of 8.
  logic [CORDW-1:0] bar_idx;
  logic [2:0]       bar;
  assign bar_idx = sx / BAR_W;
  assign bar     = (bar_idx > CORDW'(7)) ? 3'd7 : bar_idx[2:0];

  logic [COLW-1:0] r_d, g_d, b_d;
  logic            hsync_d, vsync_d;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_raw) begin
      case (mode_d)
        MODE_STATIC: begin
          if (sx > X_LO && sx < X_HI && sy > Y_LO && sy < Y_HI) begin
            r_d = ONES; g_d = ONES; b_d = ONES;
          end else begin
            r_d = BG_R; g_d = BG_G; b_d = BG_B;
          end
        end
        MODE_BARS: begin
          r_d = {COLW{bar[2]}};
          g_d = {COLW{bar[1]}};
          b_d = {COLW{bar[0]}};
        end
        MODE_BOUNCE: begin
          if (sx >= bx_d && {1'b0, sx} < ({1'b0, bx_d} + BOX_W) &&
              sy >= by_d && {1'b0, sy} < ({1'b0, by_d} + BOX_W)) begin
            r_d = ONES; g_d = ONES; b_d = ONES;
          end
        end
        MODE_GRADIENT: begin
          r_d = COLW'(GW'(sx) >> 5);
          g_d = COLW'(GW'(sy) >> 5);
          b_d = COLW'(fc_d);
        end
        default: ;
      endcase
    end
  end

  assign hsync_d = hs_raw ? HS_ON : ~HS_ON;
  assign vsync_d = vs_raw ? VS_ON : ~VS_ON;

  logic            hsync_q, vsync_q, de_q, frame_q;
  logic [COLW-1:0] r_q, g_q, b_q;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      mode_q  <= MODE_STATIC;
      fc_q    <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      mode_q  <= mode_d;
      fc_q    <= fc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_raw;
      frame_q <= frame_start;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign o_sx    = sx;
  assign o_sy    = sy;
  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_de    = de_q;
  assign o_frame = frame_q;
  assign o_r     = r_q;
  assign o_g     = g_q;
  assign o_b     = b_q;

endmodule
